sub_bytes_iter: RTL and testbench
=================================

SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of S-box instances (bytes substituted per cycle); legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning the upstream state on b is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept a state.
REQ-006 SHALL have port inv, input, 1, selecting the mode: 0 = forward SubBytes, 1 = InvSubBytes.
REQ-007 SHALL have port b, input, 128, the AES state; byte i is b[8*i +: 8].
REQ-008 SHALL have port b_sb, output, 128, the substituted state, using the same byte packing; it feeds shift_rows.
REQ-009 SHALL have port out_valid, output, 1, meaning b_sb is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream accepts b_sb.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 SHALL drive in_ready high only in IDLE and out_valid high only in DONE.
REQ-013 SHALL, in IDLE on in_valid=1, capture b into the working register, latch inv, clear the group counter and enter RUN.
REQ-014 SHALL, in RUN, replace bytes [LANES*g .. LANES*g+LANES-1] with their S-box (or inverse S-box) values on each cycle, where g is the group counter; g SHALL increment by 1 per cycle.
REQ-015 SHALL process groups in ascending byte order, starting at byte 0.
REQ-016 SHALL use a counter ceil(log2(16/LANES)) bits wide, minimum 1 bit.
REQ-017 SHALL enter DONE on the cycle the last group (g = 16/LANES-1) is written; the counter SHALL NOT wrap while in RUN.
REQ-018 SHALL assert out_valid exactly 16/LANES cycles after the accepting edge (4 cycles for LANES=4).
REQ-019 SHALL hold b_sb stable in DONE while out_ready=0, with no timeout.
REQ-020 SHALL, in DONE on out_ready=1, return to IDLE; in_ready SHALL rise on the following cycle, so no same-cycle re-accept occurs.
REQ-021 SHALL ignore changes to inv and b while the FSM is outside IDLE.
REQ-022 SHALL ignore in_valid outside IDLE; upstream holds its data until in_ready.
REQ-023 SHALL, when LANES=16, spend one RUN cycle.
REQ-024 SHALL drive b_sb directly from the working register, with no combinational path from b to b_sb.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, force IDLE, counter=0, working register=0 and latched inv=0.
REQ-026 SHALL drive in_ready=1, out_valid=0 and b_sb=0 in the cycle after reset.
REQ-027 SHALL, on reset mid-RUN or mid-DONE, discard the in-flight state without ever asserting out_valid for it.
REQ-028 SHALL give rst priority over all handshake inputs in the same cycle.

Structure
REQ-029 SHALL place the FSM state enum, the forward S-box table and the inverse S-box table (256x8 each) in shared package aes_pkg, for reuse by key expansion.
REQ-030 SHALL use sub-module aes_sbox (input 8-bit byte and inv, output 8-bit byte; combinational) instantiated LANES times.
REQ-031 SHALL keep the shift_rows interface unchanged, so that b_sb connects directly to shift_rows.b.

Verification
REQ-032 SHALL cover: b = all 0x00, inv=0 -> b_sb = all 0x63, with out_valid 4 cycles after acceptance.
REQ-033 SHALL cover: bytes 0..15 = 00,10,20,...,F0 (FIPS-197 C.1), inv=0 -> bytes 63,CA,B7,04,09,53,D0,51,CD,60,E0,E7,BA,70,E1,8C.
REQ-034 SHALL cover: the C.1 result from REQ-033 fed back with inv=1 -> original 00,10,...,F0; byte 0x53 with inv=0 -> 0xED.
REQ-035 SHALL cover: out_ready held 0 for 10 cycles in DONE -> b_sb constant, out_valid constant, in_ready=0, and a new in_valid ignored.
REQ-036 SHALL cover: rst pulsed in the 2nd RUN cycle -> next cycle IDLE, b_sb=0, and no out_valid for the aborted state.
REQ-037 SHALL cover: LANES=1 and LANES=16 builds, vector from REQ-033 -> identical b_sb, with latency 16 and 1 respectively.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions.
//   sb_state_e  - state encoding of the iterative SubBytes FSM
//   SBOX        - forward S-box table, 256 x 8, indexed by input byte
//   INV_SBOX    - inverse S-box table, 256 x 8, indexed by input byte
// The tables are also meant for the key-expansion datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sb_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational single-byte AES substitution.
//   data_i [7:0] - byte to substitute
//   inv_i        - 0 = forward S-box, 1 = inverse S-box
//   data_o [7:0] - substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  assign data_o = inv_i ? INV_SBOX[data_i] : SBOX[data_i];

endmodule

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes / InvSubBytes over a 128-bit state,
// LANES bytes per cycle, groups processed in ascending byte order.
//   clk, rst      - clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake; a state is taken when both are 1
//   inv           - mode latched with the state: 0 forward, 1 inverse
//   b   [127:0]   - input state, byte i at b[8*i +: 8]
//   b_sb[127:0]   - substituted state, same packing, straight from a register
//   out_valid/out_ready - output handshake; result is held until taken
//   dbg_state_o   - current FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, out_valid is 1 only in DONE; valid
// may not be withdrawn by the producer until the transfer, and both ready
// and valid here depend only on registered state.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] b,
  output logic [127:0] b_sb,
  output logic         out_valid,
  input  logic         out_ready,
  output sb_state_e    dbg_state_o
);

  localparam int GROUPS = 16 / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_G = CNT_W'(GROUPS - 1);

  sb_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0][7:0]        work_q, work_d;
  logic                    inv_q, inv_d;
  logic [LANES-1:0][7:0]   sb_in, sb_out;

  // Select the bytes of the current group onto the S-box lanes.
  always_comb begin
    sb_in = '0;
    for (int i = 0; i < 16; i++) begin
      if ((i / LANES) == int'(cnt_q)) sb_in[i % LANES] = work_q[i];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox u_sbox (
      .data_i (sb_in[l]),
      .inv_i  (inv_q),
      .data_o (sb_out[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = b;
          inv_d   = inv;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < 16; i++) begin
          if ((i / LANES) == int'(cnt_q)) work_d[i] = sb_out[i % LANES];
        end
        // Hold the counter on the last group instead of wrapping.
        if (cnt_q == LAST_G) state_d = DONE;
        else                 cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

  assign b_sb        = work_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: three instances (LANES = 4, 1, 16) checked
// against an S-box model computed from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_iter;
  import aes_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        in_valid_v, in_ready_v, inv_v, out_valid_v, out_ready_v;
  logic [2:0][127:0] b_v, b_sb_v;
  sb_state_e         st0, st1, st2;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   m_fwd [256];
  logic [7:0]   m_inv [256];

  localparam logic [127:0] C1_IN  = 128'hf0e0d0c0b0a090807060504030201000;
  localparam logic [127:0] C1_OUT = 128'h8ce170bae7e060cd51d0530904b7ca63;

  always #5 clk = ~clk;

  sub_bytes_iter #(.LANES(4)) dut_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .inv(inv_v[0]), .b(b_v[0]), .b_sb(b_sb_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .dbg_state_o(st0));
  sub_bytes_iter #(.LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .inv(inv_v[1]), .b(b_v[1]), .b_sb(b_sb_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .dbg_state_o(st1));
  sub_bytes_iter #(.LANES(16)) dut_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .inv(inv_v[2]), .b(b_v[2]), .b_sb(b_sb_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .dbg_state_o(st2));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = c;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_model();
    logic [7:0] g;
    for (int x = 0; x < 256; x++) begin
      g = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) g = 8'(y);
      m_fwd[x] = g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) m_inv[m_fwd[x]] = 8'(x);
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic mode);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = mode ? m_inv[s[8*i +: 8]] : m_fwd[s[8*i +: 8]];
    return r;
  endfunction

  function automatic int lanes_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 16;
  endfunction

  // ---------------- driver ----------------
  // Offers one state to instance k, scrambles b/inv after acceptance,
  // waits for out_valid, returns the result and the latency in cycles.
  task automatic run_txn(input int k, input logic [127:0] data, input logic mode,
                         output logic [127:0] res, output int lat);
    int guard;
    @(negedge clk);
    b_v[k] = data; inv_v[k] = mode; in_valid_v[k] = 1'b1;
    guard = 0;
    while (!in_ready_v[k] && guard < 50) begin @(negedge clk); guard++; end
    chk("accept_seen", {127'd0, in_ready_v[k]}, 128'd1);
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    b_v[k] = {$urandom, $urandom, $urandom, $urandom};
    inv_v[k] = ~mode;
    lat = 0;
    while (!out_valid_v[k] && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("out_valid_seen", {127'd0, out_valid_v[k]}, 128'd1);
    res = b_sb_v[k];
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
    chk("in_ready_after_done", {127'd0, in_ready_v[k]}, 128'd1);
    chk("out_valid_after_done", {127'd0, out_valid_v[k]}, 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, v, snap;
    int lat, k, guard;

    rst = 1'b1;
    in_valid_v = '0; out_ready_v = '0; inv_v = '0; b_v = '0;
    build_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of every instance.
    for (int j = 0; j < 3; j++) begin
      chk("rst_in_ready", {127'd0, in_ready_v[j]}, 128'd1);
      chk("rst_out_valid", {127'd0, out_valid_v[j]}, 128'd0);
      chk("rst_b_sb", b_sb_v[j], 128'd0);
    end
    chk("rst_state", 128'(st0), 128'(IDLE));

    // All zeros forward.
    run_txn(0, 128'd0, 1'b0, res, lat);
    chk("zero_data", res, {16{8'h63}});
    chk("zero_lat", 128'(lat), 128'd4);

    // FIPS-197 C.1 on each build, then the inverse back.
    for (int j = 0; j < 3; j++) begin
      run_txn(j, C1_IN, 1'b0, res, lat);
      chk("c1_fwd", res, C1_OUT);
      chk("c1_lat", 128'(lat), 128'(16 / lanes_of(j)));
      run_txn(j, C1_OUT, 1'b1, res, lat);
      chk("c1_inv", res, C1_IN);
    end

    // 0x53 -> 0xED in byte 0.
    v = {$urandom, $urandom, $urandom, $urandom};
    v[7:0] = 8'h53;
    run_txn(0, v, 1'b0, res, lat);
    chk("byte_53", 128'(res[7:0]), 128'h ed);
    chk("byte_53_rest", res, model(v, 1'b0));

    // Stall in DONE for 10 cycles with a competing in_valid.
    v = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    b_v[0] = v; inv_v[0] = 1'b0; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    guard = 0;
    while (!out_valid_v[0] && guard < 64) begin @(posedge clk); #1; guard++; end
    chk("stall_reach_done", {127'd0, out_valid_v[0]}, 128'd1);
    snap = b_sb_v[0];
    chk("stall_result", snap, model(v, 1'b0));
    b_v[0] = ~v; inv_v[0] = 1'b1; in_valid_v[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("stall_b_sb", b_sb_v[0], snap);
      chk("stall_out_valid", {127'd0, out_valid_v[0]}, 128'd1);
      chk("stall_in_ready", {127'd0, in_ready_v[0]}, 128'd0);
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    chk("stall_release", {127'd0, in_ready_v[0]}, 128'd1);

    // Reset in the 2nd RUN cycle aborts the state.
    @(negedge clk);
    b_v[0] = {$urandom, $urandom, $urandom, $urandom}; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", {127'd0, in_ready_v[0]}, 128'd1);
    chk("abort_b_sb", b_sb_v[0], 128'd0);
    chk("abort_state", 128'(st0), 128'(IDLE));
    guard = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid_v[0]) guard++;
    end
    out_ready_v[0] = 1'b0;
    chk("abort_no_out_valid", 128'(guard), 128'd0);

    // Randomized traffic across the three builds.
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 2);
      v = {$urandom, $urandom, $urandom, $urandom};
      inv_v[k] = 1'($urandom_range(0, 1));
      exp_q.push_back(model(v, inv_v[k]));
      run_txn(k, v, inv_v[k], res, lat);
      chk("rand_data", res, exp_q.pop_front());
      chk("rand_lat", 128'(lat), 128'(16 / lanes_of(k)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
